unshuffler: RTL and testbench



---
 rtl/unshuffler_pkg.sv | 21 ++
 rtl/unshuffler_lane_mux.sv | 21 ++
 rtl/unshuffler.sv | 149 ++++++++++++++
 tb/tb_unshuffler.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/unshuffler_pkg.sv
// Shared constants for the unshuffler: FSM state encoding and lane-index width helper.
package unshuffler_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_INVERT = 2'd1,
    S_APPLY  = 2'd2,
    S_OUT    = 2'd3
  } state_t;

  // Bits needed to index n lanes (ceil(log2(n))).
  function automatic int C_LOG_2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/unshuffler_lane_mux.sv
// One-of-NUM_DATA lane selector; purely combinational.
module unshuffler_lane_mux
  import unshuffler_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_DATA   = 16
) (
  input  logic [DATA_WIDTH*NUM_DATA-1:0]      i_data,
  input  logic [C_LOG_2(NUM_DATA)-1:0]        i_sel,
  output logic [DATA_WIDTH-1:0]               o_data
);

  logic [DATA_WIDTH-1:0] w_lane [NUM_DATA];

  for (genvar i = 0; i < NUM_DATA; i++) begin : g_unpack
    assign w_lane[i] = i_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign o_data = w_lane[i_sel];

endmodule

// File: rtl/unshuffler.sv
// Restores original lane order from a gathered vector: inverts the control word one lane
// per cycle, then scatters through per-lane muxes. Flags control words that are not permutations.
module unshuffler
  import unshuffler_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_DATA   = 16
) (
  input  logic                                   ACLK,
  input  logic                                   RESET,
  input  logic                                   IN_VALID,
  output logic                                   IN_READY,
  input  logic [DATA_WIDTH*NUM_DATA-1:0]         DATA_IN,
  input  logic [C_LOG_2(NUM_DATA)*NUM_DATA-1:0]  CTRL_IN,
  output logic                                   OUT_VALID,
  input  logic                                   OUT_READY,
  output logic [DATA_WIDTH*NUM_DATA-1:0]         DATA_OUT,
  output logic                                   PERM_ERR
);

  localparam int CTRL_WIDTH = C_LOG_2(NUM_DATA);
  localparam logic [CTRL_WIDTH-1:0] C_LAST = CTRL_WIDTH'(NUM_DATA - 1);

  state_t                            r_state;
  state_t                            w_state_nxt;
  logic                              r_in_ready;
  logic                              r_out_valid;
  logic                              r_perm_err;
  logic [DATA_WIDTH*NUM_DATA-1:0]    r_data_out;
  logic [DATA_WIDTH*NUM_DATA-1:0]    r_data;
  logic [CTRL_WIDTH*NUM_DATA-1:0]    r_ctrl;
  logic [CTRL_WIDTH-1:0]             r_idx;
  logic [NUM_DATA-1:0]               r_seen;
  logic                              r_coll;
  logic [CTRL_WIDTH-1:0]             r_inv [NUM_DATA];

  logic                              w_accept;
  logic                              w_out_hs;
  logic [CTRL_WIDTH-1:0]             w_k;
  logic [CTRL_WIDTH-1:0]             w_ctrl_lane [NUM_DATA];
  logic [DATA_WIDTH-1:0]             w_mux [NUM_DATA];
  logic [DATA_WIDTH*NUM_DATA-1:0]    w_data_out;
  logic                              w_perm_err;

  for (genvar i = 0; i < NUM_DATA; i++) begin : g_ctrl
    assign w_ctrl_lane[i] = r_ctrl[i*CTRL_WIDTH +: CTRL_WIDTH];
  end

  assign w_k = w_ctrl_lane[r_idx];

  // Scatter: output lane k takes the input lane that claimed index k; unclaimed lanes read zero.
  for (genvar k = 0; k < NUM_DATA; k++) begin : g_lane
    unshuffler_lane_mux #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_DATA   (NUM_DATA)
    ) u_mux (
      .i_data (r_data),
      .i_sel  (r_inv[k]),
      .o_data (w_mux[k])
    );
    assign w_data_out[k*DATA_WIDTH +: DATA_WIDTH] = r_seen[k] ? w_mux[k] : '0;
  end

  assign w_perm_err = r_coll | ~&r_seen;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_out_hs    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (IN_VALID && r_in_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = S_INVERT;
        end
      end
      S_INVERT: begin
        if (r_idx == C_LAST) w_state_nxt = S_APPLY;
      end
      S_APPLY: w_state_nxt = S_OUT;
      S_OUT: begin
        if (OUT_READY) begin
          w_out_hs    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (RESET) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_perm_err  <= 1'b0;
      r_data_out  <= '0;
      r_idx       <= '0;
      r_seen      <= '0;
      r_coll      <= 1'b0;
      for (int i = 0; i < NUM_DATA; i++) r_inv[i] <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt == S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_idx  <= '0;
            r_seen <= '0;
            r_coll <= 1'b0;
            for (int i = 0; i < NUM_DATA; i++) r_inv[i] <= '0;
          end
        end
        S_INVERT: begin
          // Lowest lane claiming an index wins; later duplicates only raise the collision flag.
          if (!r_seen[w_k]) begin
            r_inv[w_k]  <= r_idx;
            r_seen[w_k] <= 1'b1;
          end else begin
            r_coll <= 1'b1;
          end
          if (r_idx != C_LAST) r_idx <= r_idx + 1'b1;
        end
        S_APPLY: begin
          r_data_out  <= w_data_out;
          r_perm_err  <= w_perm_err;
          r_out_valid <= 1'b1;
        end
        S_OUT: begin
          if (w_out_hs) r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (w_accept && !RESET) begin
      r_data <= DATA_IN;
      r_ctrl <= CTRL_IN;
    end
  end

  assign IN_READY  = r_in_ready;
  assign OUT_VALID = r_out_valid;
  assign DATA_OUT  = r_data_out;
  assign PERM_ERR  = r_perm_err;

endmodule

// File: tb/tb_unshuffler.sv
// Directed bench for unshuffler with a reference-model scoreboard checked on output handshakes.
module tb_unshuffler;

  localparam int DW = 16;
  localparam int ND = 16;
  localparam int CW = 4;
  localparam int VW = DW * ND;
  localparam int CV = CW * ND;

  typedef struct {
    logic [VW-1:0] d;
    logic          e;
  } exp_t;

  logic          clk = 1'b0;
  logic          RESET;
  logic          IN_VALID;
  logic          IN_READY;
  logic [VW-1:0] DATA_IN;
  logic [CV-1:0] CTRL_IN;
  logic          OUT_VALID;
  logic          OUT_READY;
  logic [VW-1:0] DATA_OUT;
  logic          PERM_ERR;

  int   n_pass  = 0;
  int   n_fail  = 0;
  int   n_total = 0;
  int   cyc     = 0;
  exp_t sb[$];

  unshuffler #(.DATA_WIDTH(DW), .NUM_DATA(ND)) dut (
    .ACLK      (clk),
    .RESET     (RESET),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .DATA_IN   (DATA_IN),
    .CTRL_IN   (CTRL_IN),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .DATA_OUT  (DATA_OUT),
    .PERM_ERR  (PERM_ERR)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference inverse: output lane k takes the lowest input lane whose index equals k.
  function automatic void model(input logic [VW-1:0] d, input logic [CV-1:0] c,
                                output logic [VW-1:0] o, output logic e);
    logic found;
    o = '0;
    e = 1'b0;
    for (int k = 0; k < ND; k++) begin
      found = 1'b0;
      for (int i = 0; i < ND; i++) begin
        if (!found && c[i*CW +: CW] == CW'(k)) begin
          o[k*DW +: DW] = d[i*DW +: DW];
          found = 1'b1;
        end
      end
      if (!found) e = 1'b1;
    end
  endfunction

  // Scoreboard: push on accepted input, pop and compare on output handshake.
  always @(negedge clk) begin
    exp_t x;
    if (!RESET && IN_VALID && IN_READY) begin
      model(DATA_IN, CTRL_IN, x.d, x.e);
      sb.push_back(x);
    end
    if (!RESET && OUT_VALID && OUT_READY) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_out", VW'(OUT_VALID), '0);
      end else begin
        x = sb.pop_front();
        check("sb_data", DATA_OUT, x.d);
        check("sb_perm_err", VW'(PERM_ERR), VW'(x.e));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [VW-1:0] d, input logic [CV-1:0] c, input string tag);
    int n;
    n = 0;
    while (!IN_READY && n < 60) begin
      tick();
      n++;
    end
    check({tag, "_in_ready"}, VW'(IN_READY), VW'(1));
    DATA_IN  = d;
    CTRL_IN  = c;
    IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!OUT_VALID && n < 40);
    check({tag, "_latency"}, VW'(n), VW'(17));
  endtask

  function automatic void rand_perm(output logic [CV-1:0] c);
    int p[ND];
    int j, t;
    for (int i = 0; i < ND; i++) p[i] = i;
    for (int i = ND - 1; i > 0; i--) begin
      j = $urandom_range(i, 0);
      t = p[i]; p[i] = p[j]; p[j] = t;
    end
    for (int i = 0; i < ND; i++) c[i*CW +: CW] = CW'(p[i]);
  endfunction

  initial begin
    logic [VW-1:0] d, d2, eo;
    logic [CV-1:0] c, c2;
    logic          ee, r;
    int            last, acc, guard;

    RESET = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b1; DATA_IN = '0; CTRL_IN = '0;
    repeat (3) tick();
    check("rst_in_ready", VW'(IN_READY), '0);
    check("rst_out_valid", VW'(OUT_VALID), '0);
    check("rst_data_out", DATA_OUT, '0);
    check("rst_perm_err", VW'(PERM_ERR), '0);
    RESET = 1'b0;
    tick();
    check("post_rst_in_ready", VW'(IN_READY), VW'(1));

    // Identity
    for (int i = 0; i < ND; i++) begin
      d[i*DW +: DW] = DW'(i);
      c[i*CW +: CW] = CW'(i);
    end
    send(d, c, "ident");
    check("ident_out", DATA_OUT, d);
    check("ident_err", VW'(PERM_ERR), '0);
    tick();

    // Reversal
    for (int i = 0; i < ND; i++) begin
      d[i*DW +: DW] = DW'(16'h1000 + i);
      c[i*CW +: CW] = CW'(15 - i);
    end
    send(d, c, "rev");
    check("rev_lane0", VW'(DATA_OUT[0 +: DW]), VW'(16'h100F));
    check("rev_lane15", VW'(DATA_OUT[15*DW +: DW]), VW'(16'h1000));
    check("rev_err", VW'(PERM_ERR), '0);
    tick();

    // Collision: every lane claims index 3
    for (int i = 0; i < ND; i++) begin
      d[i*DW +: DW] = DW'(i + 1);
      c[i*CW +: CW] = CW'(3);
    end
    eo = '0;
    eo[3*DW +: DW] = 16'h0001;
    send(d, c, "coll");
    check("coll_out", DATA_OUT, eo);
    check("coll_err", VW'(PERM_ERR), VW'(1));
    tick();

    // Back-pressure with a competing input held valid
    OUT_READY = 1'b0;
    rand_perm(c);
    for (int i = 0; i < ND; i++) d[i*DW +: DW] = DW'($urandom);
    model(d, c, eo, ee);
    send(d, c, "bp");
    rand_perm(c2);
    for (int i = 0; i < ND; i++) d2[i*DW +: DW] = DW'($urandom);
    DATA_IN = d2; CTRL_IN = c2; IN_VALID = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_out_valid", VW'(OUT_VALID), VW'(1));
      check("bp_data", DATA_OUT, eo);
      check("bp_in_ready", VW'(IN_READY), '0);
    end
    IN_VALID = 1'b0;
    OUT_READY = 1'b1;
    tick();
    check("bp_release_in_ready", VW'(IN_READY), VW'(1));
    check("bp_release_out_valid", VW'(OUT_VALID), '0);
    send(d2, c2, "bp_next");
    tick();

    // Back-to-back random permutations
    OUT_READY = 1'b1;
    rand_perm(c);
    for (int i = 0; i < ND; i++) d[i*DW +: DW] = DW'($urandom);
    DATA_IN = d; CTRL_IN = c; IN_VALID = 1'b1;
    last = 0; acc = 0; guard = 0;
    while (acc < 5 && guard < 300) begin
      r = IN_READY;
      tick();
      guard++;
      if (r) begin
        if (acc > 0) check("b2b_interval", VW'(cyc - last), VW'(19));
        last = cyc;
        acc++;
        rand_perm(c);
        for (int i = 0; i < ND; i++) d[i*DW +: DW] = DW'($urandom);
        DATA_IN = d; CTRL_IN = c;
      end
    end
    check("b2b_accepts", VW'(acc), VW'(5));
    IN_VALID = 1'b0;
    guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      tick();
      guard++;
    end
    check("b2b_drained", VW'(sb.size()), '0);

    // Reset while inverting at idx 7
    while (!IN_READY && guard < 200) begin
      tick();
      guard++;
    end
    for (int i = 0; i < ND; i++) begin
      d[i*DW +: DW] = DW'(16'hABC0 + i);
      c[i*CW +: CW] = CW'(5);
    end
    DATA_IN = d; CTRL_IN = c; IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0;
    repeat (7) tick();
    RESET = 1'b1;
    tick();
    check("midrst_in_ready", VW'(IN_READY), '0);
    check("midrst_out_valid", VW'(OUT_VALID), '0);
    check("midrst_data_out", DATA_OUT, '0);
    check("midrst_perm_err", VW'(PERM_ERR), '0);
    sb.delete();
    RESET = 1'b0;
    tick();
    check("midrst_release_in_ready", VW'(IN_READY), VW'(1));
    for (int i = 0; i < ND; i++) begin
      d[i*DW +: DW] = DW'(16'h5000 + i);
      c[i*CW +: CW] = CW'(15 - i);
    end
    send(d, c, "after_rst");
    check("after_rst_lane0", VW'(DATA_OUT[0 +: DW]), VW'(16'h500F));
    check("after_rst_err", VW'(PERM_ERR), '0);
    tick();
    tick();
    check("final_drained", VW'(sb.size()), '0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
